direct_sched: RTL and testbench

DIRECT_SCHED -- requirements
Module: direct_sched

---
 rtl/direct_sched_pkg.sv | 44 ++++
 rtl/direct_sched_fifo.sv | 54 +++++
 rtl/direct_sched.sv | 201 ++++++++++++++++++++
 tb/tb_direct_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/direct_sched_pkg.sv
// Shared shader types plus the class/phase encodings used by the direct-lighting scheduler.
`ifndef MISS_COLOR
`define MISS_COLOR 32'h3DCC_CCCD
`endif

package direct_sched_pkg;

    typedef logic [7:0]  rayID_t;
    typedef logic [31:0] float_t;

    typedef struct packed {
        rayID_t rayID;
        float_t color;
    } calc_direct_to_BM_t;

    localparam float_t MISS_COLOR_C = `MISS_COLOR;

    typedef enum logic [1:0] {
        CL_LIT  = 2'd0,
        CL_AMB  = 2'd1,
        CL_MISS = 2'd2,
        CL_BAD  = 2'd3
    } class_e;

    typedef enum logic [1:0] {
        PH_V0 = 2'd0,
        PH_V1 = 2'd1,
        PH_V2 = 2'd2
    } phase_e;

    function automatic class_e classify(input logic is_shadow, input logic miss);
        if (is_shadow) return miss ? CL_LIT : CL_AMB;
        return miss ? CL_MISS : CL_BAD;
    endfunction

    function automatic class_e next_cls(input class_e c);
        case (c)
            CL_LIT:  return CL_AMB;
            CL_AMB:  return CL_MISS;
            default: return CL_LIT;
        endcase
    endfunction

endpackage

// File: rtl/direct_sched_fifo.sv
// Registered-storage FIFO; data pushed in one cycle is visible on o_dout from the next.
module sched_fifo
    import direct_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= inc(r_wr);
            if (w_pop)  r_rd <= inc(r_rd);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/direct_sched.sv
// Phase-strobed issue of shading rays into lit/ambient pipes, delay-matched result capture,
// credit-guarded per-class FIFOs and a round-robin output arbiter with stall hold.
module direct_sched
    import direct_sched_pkg::*;
#(
    parameter int unsigned LAT_LIT = 99,
    parameter int unsigned LAT_AMB = 5,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic                                   v0,
    output logic                                   v1,
    output logic                                   v2,
    input  logic                                   in_valid,
    output logic                                   in_stall,
    input  logic                                   in_is_shadow,
    input  logic                                   in_miss,
    input  logic [$bits(rayID_t)-1:0]              in_rayID,
    output logic                                   issue_lit,
    output logic                                   issue_amb,
    output logic [$bits(rayID_t)-1:0]              issue_rayID,
    input  logic [$bits(float_t)-1:0]              lit_color,
    input  logic [$bits(float_t)-1:0]              amb_color,
    output logic                                   out_valid,
    input  logic                                   out_stall,
    output logic [$bits(calc_direct_to_BM_t)-1:0] out_data,
    output logic                                   err_bad_class
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned W  = $bits(calc_direct_to_BM_t);

    phase_e             r_phase;
    phase_e             w_phase_nxt;
    class_e             w_cls;
    logic               w_credit_ok;
    logic               w_accept;
    logic [CW-1:0]      r_credit [3];
    logic [2:0]         w_take;
    logic [2:0]         w_push;
    logic [2:0]         w_pop;
    logic [2:0]         w_empty;
    logic [2:0]         w_full;
    logic [2:0]         w_ne;
    logic               r_err;
    logic [LAT_LIT-1:0] r_lit_v;
    rayID_t             r_lit_id [LAT_LIT];
    logic [LAT_AMB-1:0] r_amb_v;
    rayID_t             r_amb_id [LAT_AMB];
    calc_direct_to_BM_t w_din [3];
    calc_direct_to_BM_t w_head [3];
    class_e             r_ptr;
    class_e             r_hold_cls;
    logic               r_hold;
    class_e             w_c2;
    class_e             w_c3;
    class_e             w_grant;
    logic               w_xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_phase <= PH_V0;
        else      r_phase <= w_phase_nxt;
    end

    always_comb begin
        w_phase_nxt = PH_V0;
        case (r_phase)
            PH_V0:   w_phase_nxt = PH_V1;
            PH_V1:   w_phase_nxt = PH_V2;
            default: w_phase_nxt = PH_V0;
        endcase
    end

    assign v0 = (r_phase == PH_V0);
    assign v1 = (r_phase == PH_V1);
    assign v2 = (r_phase == PH_V2);

    assign w_cls = classify(in_is_shadow, in_miss);

    // The full term is redundant with the credit but keeps the FIFO guard explicit.
    always_comb begin
        w_credit_ok = 1'b1;
        case (w_cls)
            CL_LIT:  w_credit_ok = (r_credit[0] != '0) && !w_full[0];
            CL_AMB:  w_credit_ok = (r_credit[1] != '0) && !w_full[1];
            CL_MISS: w_credit_ok = (r_credit[2] != '0) && !w_full[2];
            default: w_credit_ok = 1'b1;
        endcase
    end

    assign w_accept    = rst && in_valid && v0 && w_credit_ok;
    assign in_stall    = rst && in_valid && !(v0 && w_credit_ok);
    assign issue_lit   = w_accept && (w_cls == CL_LIT);
    assign issue_amb   = w_accept && (w_cls == CL_AMB);
    assign issue_rayID = (issue_lit || issue_amb) ? in_rayID : '0;
    assign w_take      = {w_accept && (w_cls == CL_MISS), issue_amb, issue_lit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < 3; c++) r_credit[c] <= CW'(DEPTH);
            r_err <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < 3; c++) begin
                if (w_take[c] && !w_pop[c])      r_credit[c] <= r_credit[c] - CW'(1);
                else if (!w_take[c] && w_pop[c]) r_credit[c] <= r_credit[c] + CW'(1);
            end
            if (w_accept && (w_cls == CL_BAD)) r_err <= 1'b1;
        end
    end

    assign err_bad_class = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lit_v <= '0;
            for (int unsigned i = 0; i < LAT_LIT; i++) r_lit_id[i] <= '0;
        end else begin
            r_lit_v[0]  <= issue_lit;
            r_lit_id[0] <= in_rayID;
            for (int unsigned i = 1; i < LAT_LIT; i++) begin
                r_lit_v[i]  <= r_lit_v[i-1];
                r_lit_id[i] <= r_lit_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_amb_v <= '0;
            for (int unsigned i = 0; i < LAT_AMB; i++) r_amb_id[i] <= '0;
        end else begin
            r_amb_v[0]  <= issue_amb;
            r_amb_id[0] <= in_rayID;
            for (int unsigned i = 1; i < LAT_AMB; i++) begin
                r_amb_v[i]  <= r_amb_v[i-1];
                r_amb_id[i] <= r_amb_id[i-1];
            end
        end
    end

    assign w_push = {w_take[2], r_amb_v[LAT_AMB-1], r_lit_v[LAT_LIT-1]};
    assign w_din[0] = '{rayID: r_lit_id[LAT_LIT-1], color: lit_color};
    assign w_din[1] = '{rayID: r_amb_id[LAT_AMB-1], color: amb_color};
    assign w_din[2] = '{rayID: in_rayID, color: MISS_COLOR_C};

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        sched_fifo #(
            .WIDTH (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_push  (w_push[g]),
            .i_din   (w_din[g]),
            .i_pop   (w_pop[g]),
            .o_dout  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
    end

    assign w_ne      = ~w_empty;
    assign out_valid = |w_ne;
    assign w_c2      = next_cls(r_ptr);
    assign w_c3      = next_cls(w_c2);

    // A stalled grant is latched so a late push into a higher-priority class cannot steal it.
    always_comb begin
        w_grant = r_ptr;
        if (r_hold)            w_grant = r_hold_cls;
        else if (w_ne[r_ptr])  w_grant = r_ptr;
        else if (w_ne[w_c2])   w_grant = w_c2;
        else                   w_grant = w_c3;
    end

    always_comb begin
        out_data = w_head[0];
        case (w_grant)
            CL_AMB:  out_data = w_head[1];
            CL_MISS: out_data = w_head[2];
            default: out_data = w_head[0];
        endcase
    end

    assign w_xfer = out_valid && !out_stall;
    assign w_pop  = {w_xfer && (w_grant == CL_MISS), w_xfer && (w_grant == CL_AMB),
                     w_xfer && (w_grant == CL_LIT)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= CL_LIT;
            r_hold     <= 1'b0;
            r_hold_cls <= CL_LIT;
        end else begin
            r_hold <= out_valid && out_stall;
            if (out_valid && out_stall) r_hold_cls <= w_grant;
            if (w_xfer) r_ptr <= next_cls(w_grant);
        end
    end

endmodule

// File: tb/tb_direct_sched.sv
// Bench for direct_sched: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based model of the scheduler.
module tb_direct_sched;
    import direct_sched_pkg::*;

    localparam int unsigned LAT_LIT = 12;
    localparam int unsigned LAT_AMB = 5;
    localparam int unsigned DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               v0, v1, v2;
    logic               in_valid = 1'b0;
    logic               in_stall;
    logic               in_is_shadow = 1'b0;
    logic               in_miss = 1'b0;
    rayID_t             in_rayID = '0;
    logic               issue_lit, issue_amb;
    rayID_t             issue_rayID;
    float_t             lit_color = '0;
    float_t             amb_color = '0;
    logic               out_valid;
    logic               out_stall = 1'b0;
    calc_direct_to_BM_t out_data;
    logic               err_bad_class;

    always #5 clk = ~clk;

    direct_sched #(
        .LAT_LIT (LAT_LIT),
        .LAT_AMB (LAT_AMB),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .v0            (v0),
        .v1            (v1),
        .v2            (v2),
        .in_valid      (in_valid),
        .in_stall      (in_stall),
        .in_is_shadow  (in_is_shadow),
        .in_miss       (in_miss),
        .in_rayID      (in_rayID),
        .issue_lit     (issue_lit),
        .issue_amb     (issue_amb),
        .issue_rayID   (issue_rayID),
        .lit_color     (lit_color),
        .amb_color     (amb_color),
        .out_valid     (out_valid),
        .out_stall     (out_stall),
        .out_data      (out_data),
        .err_bad_class (err_bad_class)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     due;
        rayID_t id;
    } pend_t;

    pend_t              lpipe[$];
    pend_t              apipe[$];
    calc_direct_to_BM_t mq[3][$];
    int                 m_credit[3];
    int                 m_phase, m_ptr, m_hold_cls, mcyc;
    bit                 m_hold, m_err;

    task automatic model_reset();
        lpipe.delete();
        apipe.delete();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            m_credit[c] = DEPTH;
        end
        m_phase = 0; m_ptr = 0; m_hold = 0; m_hold_cls = 0; m_err = 0;
    endtask

    initial begin
        mcyc = 0;
        model_reset();
    end

    always @(negedge clk) begin
        int cls, g, any;
        bit ok, acc;
        calc_direct_to_BM_t e;
        if (!rst) begin
            check("rst_v0", v0, 1'b1);
            check("rst_v1v2", {v1, v2}, 2'b00);
            check("rst_in_stall", in_stall, 1'b0);
            check("rst_issue", {issue_lit, issue_amb}, 2'b00);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_err", err_bad_class, 1'b0);
            model_reset();
        end else begin
            cls = in_is_shadow ? (in_miss ? 0 : 1) : (in_miss ? 2 : 3);
            ok  = (cls == 3) ? 1'b1 : (m_credit[cls] > 0);
            acc = in_valid && (m_phase == 0) && ok;
            check("v0", v0, m_phase == 0);
            check("v1", v1, m_phase == 1);
            check("v2", v2, m_phase == 2);
            check("in_stall", in_stall, in_valid && !((m_phase == 0) && ok));
            check("issue_lit", issue_lit, acc && (cls == 0));
            check("issue_amb", issue_amb, acc && (cls == 1));
            if (acc && cls < 2) check("issue_rayID", issue_rayID, in_rayID);
            check("err_bad_class", err_bad_class, m_err);
            any = mq[0].size() + mq[1].size() + mq[2].size();
            check("out_valid", out_valid, any > 0);
            g = 0;
            if (any > 0) begin
                if (m_hold) g = m_hold_cls;
                else begin
                    for (int k = 2; k >= 0; k--)
                        if (mq[(m_ptr + k) % 3].size() > 0) g = (m_ptr + k) % 3;
                end
                check("out_data", out_data, mq[g][0]);
            end
            m_hold = (any > 0) && out_stall;
            m_hold_cls = g;
            if (any > 0 && !out_stall) begin
                void'(mq[g].pop_front());
                m_credit[g]++;
                m_ptr = (g + 1) % 3;
            end
            if (acc) begin
                if (cls < 3) m_credit[cls]--;
                case (cls)
                    0: lpipe.push_back('{due: mcyc + LAT_LIT, id: in_rayID});
                    1: apipe.push_back('{due: mcyc + LAT_AMB, id: in_rayID});
                    2: begin e.rayID = in_rayID; e.color = MISS_COLOR_C; mq[2].push_back(e); end
                    default: m_err = 1;
                endcase
            end
            while (lpipe.size() > 0 && lpipe[0].due == mcyc) begin
                e.rayID = lpipe[0].id; e.color = lit_color;
                mq[0].push_back(e);
                void'(lpipe.pop_front());
            end
            while (apipe.size() > 0 && apipe[0].due == mcyc) begin
                e.rayID = apipe[0].id; e.color = amb_color;
                mq[1].push_back(e);
                void'(apipe.pop_front());
            end
            m_phase = (m_phase + 1) % 3;
            mcyc++;
        end
    end

    // ---------------- stimulus ----------------
    int scyc = 0;
    bit rnd_colors = 0;

    task automatic set_colors();
        if (rnd_colors) begin
            lit_color = $urandom;
            amb_color = $urandom;
        end else begin
            lit_color = {16'hC0DE, 16'(scyc)};
            amb_color = {16'hA0B0, 16'(scyc)};
        end
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        scyc++;
        set_colors();
    endtask

    task automatic drive(input bit v, input bit sh, input bit ms, input int id);
        in_valid = v; in_is_shadow = sh; in_miss = ms; in_rayID = rayID_t'(id);
    endtask

    task automatic go_to(input int n);
        while (scyc < n) begin
            cyc_begin();
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        scyc = 0;
        set_colors();
    endtask

    initial begin
        calc_direct_to_BM_t exp_d;
        int n, rel, acc_at, cnt, r;
        bit found;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        release_reset();
        @(negedge clk);
        check("release_v0", v0, 1'b1);

        // lit ray 5 offered on a v1 cycle waits for v0
        cyc_begin(); drive(1, 1, 1, 5);
        @(negedge clk); check("lit5_stall_v1", in_stall, 1'b1);
        cyc_begin();
        @(negedge clk); check("lit5_stall_v2", in_stall, 1'b1);
        cyc_begin();
        @(negedge clk);
        check("lit5_issue", issue_lit, 1'b1);
        check("lit5_issue_id", issue_rayID, 8'd5);
        go_to(15);
        @(negedge clk); check("lit5_not_early", out_valid, 1'b0);
        go_to(16);
        @(negedge clk);
        exp_d.rayID = 8'd5; exp_d.color = 32'hC0DE_000F;
        check("lit5_out_valid", out_valid, 1'b1);
        check("lit5_out_data", out_data, exp_d);

        // miss ray 7 at v0 appears next cycle for exactly one cycle
        go_to(18); drive(1, 0, 1, 7);
        @(negedge clk); check("miss7_accept", in_stall, 1'b0);
        cyc_begin(); drive(0, 0, 0, 0);
        @(negedge clk);
        exp_d.rayID = 8'd7; exp_d.color = MISS_COLOR_C;
        check("miss7_valid", out_valid, 1'b1);
        check("miss7_data", out_data, exp_d);
        cyc_begin();
        @(negedge clk); check("miss7_pulse", out_valid, 1'b0);

        // bad class: swallowed, sticky error
        go_to(21); drive(1, 0, 0, 9);
        @(negedge clk);
        check("bad_no_issue", {issue_lit, issue_amb, in_stall}, 3'b000);
        cyc_begin(); drive(0, 0, 0, 0);
        @(negedge clk);
        check("bad_err", err_bad_class, 1'b1);
        check("bad_no_out", out_valid, 1'b0);

        // randomized traffic
        rnd_colors = 1;
        repeat (3000) begin
            cyc_begin();
            r = $urandom_range(0, 15);
            drive($urandom_range(0, 2) != 0, r < 12, (r < 5) || (r >= 8 && r < 15), $urandom);
            out_stall = ($urandom_range(0, 3) == 0);
        end
        out_stall = 0;
        go_to(scyc + 40);

        // reset with lit rays in flight
        go_to(((scyc / 3) + 1) * 3 - 1);
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            cyc_begin(); drive(1, 1, 1, 100 + k);
            @(negedge clk); if (issue_lit) cnt++;
        end
        check("inflight_issued", cnt, 3);
        cyc_begin(); drive(0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) cyc_begin();
        release_reset();
        @(negedge clk); check("rerelease_v0", v0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc_begin();
            @(negedge clk); if (out_valid) cnt++;
        end
        check("inflight_discarded", cnt, 0);

        // credit exhaustion on the ambient class with the output stalled
        out_stall = 1; n = 0;
        while (n < 5) begin
            cyc_begin(); drive(0, 0, 0, 0);
            if (scyc % 3 == 0) begin
                drive(1, 1, 0, 10 + n);
                @(negedge clk);
                if (n < 4) check("amb_accept", issue_amb, 1'b1);
                else       check("amb_credit_stall", in_stall, 1'b1);
                n++;
            end
        end
        found = 0; acc_at = 0;
        cyc_begin(); out_stall = 0; rel = scyc;
        for (int k = 0; k < 30 && !found; k++) begin
            if (k > 0) cyc_begin();
            @(negedge clk);
            if (issue_amb) begin found = 1; acc_at = scyc; end
        end
        check("amb5_accepted", found, 1'b1);
        if (found) check("amb5_accept_cycle", acc_at, ((rel / 3) + 1) * 3);
        cyc_begin(); drive(0, 0, 0, 0);
        go_to(scyc + 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
